// File: rtl/rs_dsp_pkg.sv
// Shared types and constants for the rs_dsp multiply/accumulate blocks.
package rs_dsp_pkg;

    typedef enum logic [2:0] {
        FB_MULT     = 3'd0,
        FB_MAC      = 3'd1,
        FB_MAC_LOAD = 3'd2
    } feedback_e;

    localparam int DSP_A_MAX = 20;
    localparam int DSP_B_MAX = 18;
    localparam int DSP_P_W   = 38;

endpackage

// File: rtl/rs_dsp_mac_pipe_if.sv
// Sample stream into and result stream out of rs_dsp_mac_pipe.
// valid_in qualifies a, b and every control for that clock; there is no ready,
// the pipe takes one sample per clock and never stalls. valid_out qualifies z/overflow.
interface rs_dsp_mac_pipe_if #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 64
);
    logic                 valid_in;
    logic [A_WIDTH-1:0]   a;
    logic [B_WIDTH-1:0]   b;
    logic                 unsigned_a;
    logic                 unsigned_b;
    logic [2:0]           feedback;
    logic                 subtract;
    logic [5:0]           shift_right;
    logic                 round;
    logic                 valid_out;
    logic [ACC_WIDTH-1:0] z;
    logic                 overflow;

    modport master (
        output valid_in, a, b, unsigned_a, unsigned_b, feedback, subtract, shift_right, round,
        input  valid_out, z, overflow
    );

    modport slave (
        input  valid_in, a, b, unsigned_a, unsigned_b, feedback, subtract, shift_right, round,
        output valid_out, z, overflow
    );
endinterface

// File: rtl/rs_dsp_round_shift.sv
// Combinational round-half-up, saturate and arithmetic right shift of the accumulator.
module rs_dsp_round_shift #(
    parameter int ACC_WIDTH = 64,
    parameter int SATURATE  = 1
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic [5:0]                  shift_right,
    input  logic                        round,
    output logic signed [ACC_WIDTH-1:0] z,
    output logic                        sat
);
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

    logic signed [RW-1:0]        half;
    logic signed [RW-1:0]        sum;
    logic signed [ACC_WIDTH-1:0] pre;
    logic                        shift_all;

    always_comb begin
        // Rounding with a shift wider than the accumulator always lands on exactly 0.
        shift_all = round && (int'(shift_right) > ACC_WIDTH);
        half      = '0;
        if (round && shift_right != 6'd0 && !shift_all)
            half = RW'(1) << (shift_right - 6'd1);
        sum = RW'(acc) + half;
        pre = sum[ACC_WIDTH-1:0];
        sat = 1'b0;
        if (sum[RW-1] != sum[RW-2]) begin
            sat = 1'b1;
            if (SATURATE != 0)
                pre = ACC_MAX;
        end
        z = pre >>> shift_right;
        if (shift_all)
            z = '0;
    end
endmodule

// File: rtl/rs_dsp_mac_pipe.sv
// Pipelined signed/unsigned multiply and multiply-accumulate with saturation and round/shift.
// S0 (optional input reg) -> S1 product -> S2 accumulator -> S3 (optional output reg).
module rs_dsp_mac_pipe
    import rs_dsp_pkg::*;
#(
    parameter int A_WIDTH       = 20,
    parameter int B_WIDTH       = 18,
    parameter int ACC_WIDTH     = 64,
    parameter int INPUT_REG_EN  = 1,
    parameter int OUTPUT_REG_EN = 1,
    parameter int SATURATE      = 1
) (
    input logic              clk,
    input logic              lreset,
    rs_dsp_mac_pipe_if.slave bus
);
    // One guard bit per operand keeps full-width unsigned values positive; one more for negation.
    localparam int PW    = DSP_A_MAX + DSP_B_MAX + 2;
    localparam int PX_W  = DSP_P_W + 3;
    localparam int SUM_W = ((ACC_WIDTH > PX_W) ? ACC_WIDTH : PX_W) + 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (A_WIDTH < 2 || A_WIDTH > DSP_A_MAX) begin : g_bad_a
        $error("rs_dsp_mac_pipe: A_WIDTH must be 2..%0d", DSP_A_MAX);
    end
    if (B_WIDTH < 2 || B_WIDTH > DSP_B_MAX) begin : g_bad_b
        $error("rs_dsp_mac_pipe: B_WIDTH must be 2..%0d", DSP_B_MAX);
    end
    if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_bad_acc
        $error("rs_dsp_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
    end

    logic               s0_valid, s0_ua, s0_ub, s0_sub, s0_rnd;
    logic [A_WIDTH-1:0] s0_a;
    logic [B_WIDTH-1:0] s0_b;
    logic [2:0]         s0_fb;
    logic [5:0]         s0_sh;

    if (INPUT_REG_EN != 0) begin : g_s0_reg
        always_ff @(posedge clk or negedge lreset) begin
            if (!lreset) begin
                s0_valid <= 1'b0; s0_a  <= '0;   s0_b   <= '0;   s0_ua  <= 1'b0; s0_ub <= 1'b0;
                s0_fb    <= '0;   s0_sub <= 1'b0; s0_sh <= '0;   s0_rnd <= 1'b0;
            end else begin
                s0_valid <= bus.valid_in;   s0_a   <= bus.a;        s0_b  <= bus.b;
                s0_ua    <= bus.unsigned_a; s0_ub  <= bus.unsigned_b;
                s0_fb    <= bus.feedback;   s0_sub <= bus.subtract;
                s0_sh    <= bus.shift_right; s0_rnd <= bus.round;
            end
        end
    end else begin : g_s0_bypass
        assign s0_valid = bus.valid_in;    assign s0_a   = bus.a;        assign s0_b  = bus.b;
        assign s0_ua    = bus.unsigned_a;  assign s0_ub  = bus.unsigned_b;
        assign s0_fb    = bus.feedback;    assign s0_sub = bus.subtract;
        assign s0_sh    = bus.shift_right; assign s0_rnd = bus.round;
    end

    logic signed [DSP_A_MAX:0] a_ext;
    logic signed [DSP_B_MAX:0] b_ext;
    logic signed [PW-1:0]      prod;

    always_comb begin
        a_ext = s0_ua ? (DSP_A_MAX+1)'(s0_a) : (DSP_A_MAX+1)'($signed(s0_a));
        b_ext = s0_ub ? (DSP_B_MAX+1)'(s0_b) : (DSP_B_MAX+1)'($signed(s0_b));
        prod  = PW'(a_ext) * PW'(b_ext);
    end

    logic                   s1_valid, s1_rnd;
    logic signed [PX_W-1:0] s1_p;
    logic [2:0]             s1_fb;
    logic [5:0]             s1_sh;

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            s1_valid <= 1'b0; s1_p <= '0; s1_fb <= '0; s1_sh <= '0; s1_rnd <= 1'b0;
        end else begin
            s1_valid <= s0_valid;
            s1_p     <= s0_sub ? -PX_W'(prod) : PX_W'(prod);
            s1_fb    <= s0_fb;
            s1_sh    <= s0_sh;
            s1_rnd   <= s0_rnd;
        end
    end

    logic signed [SUM_W-1:0]     acc_sum;
    logic signed [ACC_WIDTH-1:0] acc, acc_next;
    logic                        acc_ovf;

    // Only MAC folds in the old sum; MULT, MAC_LOAD and reserved codes restart from the product.
    always_comb begin
        acc_sum  = ((s1_fb == FB_MAC) ? SUM_W'(acc) : '0) + SUM_W'(s1_p);
        acc_next = acc_sum[ACC_WIDTH-1:0];
        acc_ovf  = 1'b0;
        if (acc_sum > SUM_W'(ACC_MAX)) begin
            acc_ovf = 1'b1;
            if (SATURATE != 0) acc_next = ACC_MAX;
        end else if (acc_sum < SUM_W'(ACC_MIN)) begin
            acc_ovf = 1'b1;
            if (SATURATE != 0) acc_next = ACC_MIN;
        end
    end

    logic       s2_valid, s2_ovf, s2_rnd;
    logic [5:0] s2_sh;

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            acc <= '0; s2_valid <= 1'b0; s2_ovf <= 1'b0; s2_sh <= '0; s2_rnd <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc    <= acc_next;
                s2_ovf <= acc_ovf;
                s2_sh  <= s1_sh;
                s2_rnd <= s1_rnd;
            end
        end
    end

    logic signed [ACC_WIDTH-1:0] rs_z;
    logic                        rs_sat;

    rs_dsp_round_shift #(
        .ACC_WIDTH (ACC_WIDTH),
        .SATURATE  (SATURATE)
    ) u_round_shift (
        .acc         (acc),
        .shift_right (s2_sh),
        .round       (s2_rnd),
        .z           (rs_z),
        .sat         (rs_sat)
    );

    logic                 out_valid, out_ovf;
    logic [ACC_WIDTH-1:0] out_z;

    if (OUTPUT_REG_EN != 0) begin : g_s3_reg
        always_ff @(posedge clk or negedge lreset) begin
            if (!lreset) begin
                out_valid <= 1'b0; out_z <= '0; out_ovf <= 1'b0;
            end else begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_z   <= rs_z;
                    out_ovf <= s2_ovf | rs_sat;
                end
            end
        end
    end else begin : g_s3_bypass
        assign out_valid = s2_valid;
        assign out_z     = rs_z;
        assign out_ovf   = s2_ovf | rs_sat;
    end

    assign bus.valid_out = out_valid;
    assign bus.z         = out_z;
    assign bus.overflow  = out_ovf;
endmodule

// File: tb/tb_rs_dsp_mac_pipe.sv
// Bench for rs_dsp_mac_pipe: four latency variants (ACC 64) plus one ACC 40 saturating copy,
// all fed the same stream and checked against an integer reference model.
module tb_rs_dsp_mac_pipe;
  import rs_dsp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic lreset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid_in;
  logic [19:0] a;
  logic [17:0] b;
  logic        unsigned_a, unsigned_b;
  logic [2:0]  feedback;
  logic        subtract;
  logic [5:0]  shift_right;
  logic        round;

  int checks = 0;
  int errors = 0;
  longint m_acc64, m_acc40;
  logic [65:0] obs [5];

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- DUT copies and per-copy scoreboard ----------------
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int AW   = (g == 4) ? 40 : 64;
    localparam int IREG = (g == 1 || g >= 3) ? 1 : 0;
    localparam int OREG = (g >= 2) ? 1 : 0;

    rs_dsp_mac_pipe_if #(.A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(AW)) bus ();

    logic [80:0] exp_q[$];
    logic [80:0] e;
    logic [64:0] last = '0;

    assign bus.valid_in    = valid_in;
    assign bus.a           = a;
    assign bus.b           = b;
    assign bus.unsigned_a  = unsigned_a;
    assign bus.unsigned_b  = unsigned_b;
    assign bus.feedback    = feedback;
    assign bus.subtract    = subtract;
    assign bus.shift_right = shift_right;
    assign bus.round       = round;
    assign obs[g] = {bus.valid_out, bus.overflow, 64'($signed(bus.z))};

    rs_dsp_mac_pipe #(
      .A_WIDTH(20), .B_WIDTH(18), .ACC_WIDTH(AW),
      .INPUT_REG_EN(IREG), .OUTPUT_REG_EN(OREG), .SATURATE(1)
    ) dut (
      .clk    (clk),
      .lreset (lreset),
      .bus    (bus)
    );

    always @(negedge clk) begin
      if (!lreset) begin
        last = '0;
      end else if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          check($sformatf("spurious_valid_%0d", g), 66'(bus.valid_out), 66'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("z_%0d", g), 66'(obs[g][63:0]), 66'(e[63:0]));
          check($sformatf("ovf_%0d", g), 66'(bus.overflow), 66'(e[64]));
          check($sformatf("latency_cyc_%0d", g), 66'(cyc[15:0]), 66'(e[80:65]));
          last = e[64:0];
        end
      end else begin
        check($sformatf("hold_%0d", g), 66'(obs[g][64:0]), 66'(last));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic void model(inout longint acc, input longint p, input logic [2:0] fb,
                                input int w, input logic [5:0] sh, input logic rnd,
                                output longint z, output bit ovf);
    longint s, mx, mn, r;
    if (w < 64) mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    else        mx = 64'sh7FFF_FFFF_FFFF_FFFF;
    mn  = -mx - 64'sd1;
    ovf = 1'b0;
    s   = (fb == 3'd1) ? acc + p : p;
    if (w == 64 && fb == 3'd1 && acc[63] == p[63] && s[63] != acc[63]) begin
      s = acc[63] ? mn : mx; ovf = 1'b1;
    end else if (s > mx) begin
      s = mx; ovf = 1'b1;
    end else if (s < mn) begin
      s = mn; ovf = 1'b1;
    end
    acc = s;
    r = s + ((rnd && sh != 6'd0) ? (64'sd1 <<< (sh - 6'd1)) : 64'sd0);
    if (r > mx || (w == 64 && r < s)) begin
      r = mx; ovf = 1'b1;
    end
    z = r >>> sh;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_all(input longint z64, input bit o64, input longint z40, input bit o40);
    g_dut[0].exp_q.push_back({16'(cyc + 2), o64, z64});
    g_dut[1].exp_q.push_back({16'(cyc + 3), o64, z64});
    g_dut[2].exp_q.push_back({16'(cyc + 3), o64, z64});
    g_dut[3].exp_q.push_back({16'(cyc + 4), o64, z64});
    g_dut[4].exp_q.push_back({16'(cyc + 4), o40, z40});
  endtask

  task automatic clear_all();
    g_dut[0].exp_q.delete();
    g_dut[1].exp_q.delete();
    g_dut[2].exp_q.delete();
    g_dut[3].exp_q.delete();
    g_dut[4].exp_q.delete();
  endtask

  function automatic int pending();
    return g_dut[0].exp_q.size() + g_dut[1].exp_q.size() + g_dut[2].exp_q.size()
         + g_dut[3].exp_q.size() + g_dut[4].exp_q.size();
  endfunction

  task automatic send(input logic [19:0] ta, input logic [17:0] tbv, input logic ua,
                      input logic ub, input logic [2:0] fb, input logic sub,
                      input logic [5:0] sh, input logic rnd);
    longint pa, pb, p, z64, z40;
    bit o64, o40;
    @(posedge clk); #1;
    valid_in = 1'b1; a = ta; b = tbv; unsigned_a = ua; unsigned_b = ub;
    feedback = fb; subtract = sub; shift_right = sh; round = rnd;
    if (ua) pa = longint'({44'd0, ta}); else pa = longint'($signed(ta));
    if (ub) pb = longint'({46'd0, tbv}); else pb = longint'($signed(tbv));
    p = pa * pb;
    if (sub) p = -p;
    model(m_acc64, p, fb, 64, sh, rnd, z64, o64);
    model(m_acc40, p, fb, 40, sh, rnd, z40, o40);
    push_all(z64, o64, z40, o40);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_%0d", tag, i), 66'(obs[i]), 66'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    lreset = 1'b0; valid_in = 1'b0; a = '0; b = '0; unsigned_a = 1'b0; unsigned_b = 1'b0;
    feedback = '0; subtract = 1'b0; shift_right = '0; round = 1'b0;
    m_acc64 = 0; m_acc40 = 0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_state");
    lreset = 1'b1;

    // plain multiplies
    send(20'(-3), 18'd7, 1'b0, 1'b0, FB_MULT, 1'b0, 6'd0, 1'b0);
    send(20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, FB_MULT, 1'b0, 6'd0, 1'b0);
    idle();

    // accumulate stream with a bubble and a subtract
    send(20'd2, 18'd3, 1'b0, 1'b0, FB_MAC_LOAD, 1'b0, 6'd0, 1'b0);
    send(20'd4, 18'd5, 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    idle();
    send(20'd1, 18'(-10), 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b0, FB_MAC, 1'b1, 6'd0, 1'b0);
    idle();

    // round / shift
    send(20'd23, 18'd1, 1'b0, 1'b0, FB_MAC_LOAD, 1'b0, 6'd2, 1'b1);
    send(20'd23, 18'd1, 1'b0, 1'b0, FB_MULT, 1'b0, 6'd2, 1'b0);
    send(20'd22, 18'd1, 1'b0, 1'b0, FB_MULT, 1'b0, 6'd2, 1'b1);
    send(20'd22, 18'd1, 1'b0, 1'b0, FB_MULT, 1'b0, 6'd2, 1'b0);
    send(20'(-5), 18'd1, 1'b0, 1'b0, FB_MULT, 1'b0, 6'd1, 1'b1);
    idle();

    // saturation on the ACC 40 copy, then decrement from the clamp
    send(20'h7FFFF, 18'h1FFFF, 1'b0, 1'b0, FB_MAC_LOAD, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      send(20'h7FFFF, 18'h1FFFF, 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    send(20'd1, 18'd1, 1'b0, 1'b0, FB_MAC, 1'b1, 6'd0, 1'b0);
    idle();
    repeat (6) idle();

    // async reset with samples in flight
    send(20'd9, 18'd9, 1'b0, 1'b0, FB_MAC_LOAD, 1'b0, 6'd0, 1'b0);
    send(20'd8, 18'd8, 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    send(20'd7, 18'd7, 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    #2;
    lreset = 1'b0;
    valid_in = 1'b0;
    clear_all();
    m_acc64 = 0; m_acc40 = 0;
    #1;
    check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    lreset = 1'b1;
    send(20'd3, 18'd4, 1'b0, 1'b0, FB_MAC, 1'b0, 6'd0, 1'b0);
    idle();

    // random traffic with bubbles
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else send(20'($urandom()), 18'($urandom()), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 24)),
                1'($urandom_range(0, 1)));
    end
    idle();

    for (int i = 0; i < 40 && pending() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_pending", 66'(pending()), 66'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
